// File: rtl/trap_controller_pkg.sv
// Shared constants for the trap controller: exception codes, CSR addresses,
// FSM state encodings and the default trap vector.
package trap_controller_pkg;

  localparam int XLEN_32B = 1;
  localparam int XLEN_64B = 2;

  localparam logic [3:0] E_INSTR_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] E_INSTR_ACCESS_FAULT    = 4'd1;
  localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
  localparam logic [3:0] E_BREAKPOINT            = 4'd3;
  localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
  localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
  localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd7;
  localparam logic [3:0] E_ECALL                 = 4'd11;
  localparam logic [3:0] NO_E                    = 4'd15;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  localparam logic [63:0] TRAP_VECTOR_DEFAULT = 64'd0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_T_EPC   = 3'd1,
    S_T_CAUSE = 3'd2,
    S_T_TVAL  = 3'd3,
    S_IN_TRAP = 3'd4,
    S_RET     = 3'd5,
    S_HALT    = 3'd6
  } trap_state_t;

  // Load/store faults report the faulting data address as mtval.
  function automatic logic is_mem_fault(input logic [3:0] code);
    return (code == E_LOAD_ADDR_MISALIGNED)  || (code == E_LOAD_ACCESS_FAULT) ||
           (code == E_STORE_ADDR_MISALIGNED) || (code == E_STORE_ACCESS_FAULT);
  endfunction

endpackage

// File: rtl/trap_code_pipe.sv
// Two-stage F->D->E carry of fetch exception code and PC, so a fetch fault
// is reported only once its instruction reaches Execute.
module trap_code_pipe
  import trap_controller_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [3:0]   code_f,
  input  logic [W-1:0] pc_f,
  output logic [3:0]   code_e,
  output logic [W-1:0] pc_e
);

  logic [3:0]   code_p1, code_p2;
  logic [W-1:0] pc_p1, pc_p2;

  // F->D (p1) and D->E (p2); flush overrides the advance for the codes only
  always_ff @(posedge clk) begin
    if (rst) begin
      code_p1 <= NO_E;
      code_p2 <= NO_E;
      pc_p1   <= '0;
      pc_p2   <= '0;
    end else begin
      if (!stall) begin
        code_p1 <= code_f;
        code_p2 <= code_p1;
        pc_p1   <= pc_f;
        pc_p2   <= pc_p1;
      end
      if (flush) begin
        code_p1 <= NO_E;
        code_p2 <= NO_E;
      end
    end
  end

  assign code_e = code_p2;
  assign pc_e   = pc_p2;

endmodule

// File: rtl/trap_controller.sv
// Precise trap entry / MRET return: serialises mepc/mcause/mtval writes,
// flushes and redirects the pipeline, and owns the trap/reset permissions.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int XLEN = XLEN_64B,
  localparam int W = 1 << (XLEN + 4),
  parameter logic [63:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [3:0]   i_exception_code_f,
  input  logic [3:0]   i_exception_code_e,
  input  logic [W-1:0] i_pc_f,
  input  logic [W-1:0] i_alu_out_e,
  input  logic         i_mret_e,
  input  logic         i_stall,
  input  logic [W-1:0] i_mepc,
  output logic         o_csr_we,
  output logic [11:0]  o_csr_addr,
  output logic [W-1:0] o_csr_wdata,
  output logic         o_flush,
  output logic         o_pc_redirect,
  output logic [W-1:0] o_pc_target,
  output logic         o_trap_permission,
  output logic         o_reset_permission,
  output logic         o_halt
);

  trap_state_t  state, state_nxt;
  logic [3:0]   carry_code, eff_code, cap_cause, cause_q;
  logic [W-1:0] carry_pc, cap_tval, epc_q, tval_q;
  logic         take_trap, csr_we_c, flush_c, reset_perm_q;

  trap_code_pipe #(.W(W)) u_code_pipe (
    .clk    (i_clk),
    .rst    (i_rst),
    .stall  (i_stall),
    .flush  (flush_c),
    .code_f (i_exception_code_f),
    .pc_f   (i_pc_f),
    .code_e (carry_code),
    .pc_e   (carry_pc)
  );

  // Execute-stage cause wins: same instruction, and it is the older cause.
  always_comb begin
    eff_code  = (i_exception_code_e != NO_E) ? i_exception_code_e : carry_code;
    take_trap = (eff_code != NO_E) || i_mret_e;
    cap_cause = (eff_code != NO_E) ? eff_code : E_ILLEGAL_INSTR;
    cap_tval  = '0;
    if (is_mem_fault(cap_cause))
      cap_tval = i_alu_out_e;
    else if (cap_cause == E_INSTR_ADDR_MISALIGNED)
      cap_tval = carry_pc;
  end

  // Trap record, captured on the edge that leaves IDLE
  always_ff @(posedge i_clk) begin
    if (state == S_IDLE && take_trap) begin
      cause_q <= cap_cause;
      epc_q   <= carry_pc;
      tval_q  <= cap_tval;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      reset_perm_q <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && i_pc_f[20:18] == 3'b010 && i_exception_code_f == NO_E)
        reset_perm_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt         = state;
    csr_we_c          = 1'b0;
    o_csr_addr        = '0;
    o_csr_wdata       = '0;
    flush_c           = 1'b0;
    o_pc_redirect     = 1'b0;
    o_pc_target       = '0;
    o_trap_permission = 1'b0;
    o_halt            = 1'b0;
    case (state)
      S_IDLE: if (take_trap) state_nxt = S_T_EPC;
      S_T_EPC: begin
        flush_c     = 1'b1;
        csr_we_c    = 1'b1;
        o_csr_addr  = CSR_MEPC;
        o_csr_wdata = epc_q;
        state_nxt   = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        flush_c     = 1'b1;
        csr_we_c    = 1'b1;
        o_csr_addr  = CSR_MCAUSE;
        o_csr_wdata = {{(W-4){1'b0}}, cause_q};
        state_nxt   = S_T_TVAL;
      end
      S_T_TVAL: begin
        flush_c       = 1'b1;
        csr_we_c      = 1'b1;
        o_csr_addr    = CSR_MTVAL;
        o_csr_wdata   = tval_q;
        o_pc_redirect = 1'b1;
        o_pc_target   = TRAP_VECTOR[W-1:0];
        state_nxt     = S_IN_TRAP;
      end
      S_IN_TRAP: begin
        o_trap_permission = 1'b1;
        if (eff_code != NO_E) state_nxt = S_HALT;
        else if (i_mret_e)    state_nxt = S_RET;
      end
      S_RET: begin
        flush_c           = 1'b1;
        o_pc_redirect     = 1'b1;
        o_pc_target       = i_mepc;
        o_trap_permission = 1'b1;
        state_nxt         = S_IDLE;
      end
      S_HALT: begin
        o_halt  = 1'b1;
        flush_c = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A write strobe coinciding with reset is dropped along with the sequence.
  assign o_csr_we           = csr_we_c & ~i_rst;
  assign o_flush            = flush_c;
  assign o_reset_permission = reset_perm_q;

endmodule

// File: tb/tb_trap_controller.sv
// Scenario bench for trap_controller: CSR writes checked through an expected-
// write queue, control outputs checked inline per scenario.
module tb_trap_controller;
  import trap_controller_pkg::*;

  localparam int W = 64;

  typedef struct {
    logic [11:0]  addr;
    logic [W-1:0] data;
  } csr_wr_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   code_f = NO_E;
  logic [3:0]   code_e = NO_E;
  logic [W-1:0] pc_f = '0;
  logic [W-1:0] alu_out = '0;
  logic         mret = 1'b0;
  logic         stall = 1'b0;
  logic [W-1:0] mepc = '0;
  logic         csr_we;
  logic [11:0]  csr_addr;
  logic [W-1:0] csr_wdata;
  logic         flush, redirect, trap_perm, reset_perm, halt;
  logic [W-1:0] target;

  int checks = 0;
  int errors = 0;
  csr_wr_t exp_q[$];
  csr_wr_t mon_e;

  trap_controller #(.XLEN(XLEN_64B)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_exception_code_f (code_f),
    .i_exception_code_e (code_e),
    .i_pc_f             (pc_f),
    .i_alu_out_e        (alu_out),
    .i_mret_e           (mret),
    .i_stall            (stall),
    .i_mepc             (mepc),
    .o_csr_we           (csr_we),
    .o_csr_addr         (csr_addr),
    .o_csr_wdata        (csr_wdata),
    .o_flush            (flush),
    .o_pc_redirect      (redirect),
    .o_pc_target        (target),
    .o_trap_permission  (trap_perm),
    .o_reset_permission (reset_perm),
    .o_halt             (halt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (csr_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL csr_unexpected got addr=%h data=%h, none expected", csr_addr, csr_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (csr_addr !== mon_e.addr || csr_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL csr_write got addr=%h data=%h expected addr=%h data=%h",
                   csr_addr, csr_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic push(input logic [11:0] a, input logic [W-1:0] d);
    csr_wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({csr_we, flush, redirect, trap_perm, reset_perm, halt} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_outputs got we/fl/rd/tp/rp/h=%b expected 000010",
               {csr_we, flush, redirect, trap_perm, reset_perm, halt});
    end
    checks++;
    if (target !== '0) begin
      errors++;
      $display("FAIL reset_target got %h expected 0", target);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (reset_perm !== 1'b1) begin
      errors++;
      $display("FAIL reset_perm_hold got %b expected 1", reset_perm);
    end
    pc_f = 64'h80000;
    @(negedge clk);
    checks++;
    if (reset_perm !== 1'b0) begin
      errors++;
      $display("FAIL reset_perm_clear got %b expected 0", reset_perm);
    end
    pc_f = '0;
    @(negedge clk);
    checks++;
    if (reset_perm !== 1'b0) begin
      errors++;
      $display("FAIL reset_perm_sticky got %b expected 0", reset_perm);
    end
  endtask

  // Presents nothing new; walks T_CAUSE, T_TVAL and lands in IN_TRAP.
  task automatic finish_entry(input string name);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (redirect !== 1'b1 || target !== '0 || trap_perm !== 1'b0) begin
      errors++;
      $display("FAIL %s_redirect got rd=%b tgt=%h tp=%b expected rd=1 tgt=0 tp=0",
               name, redirect, target, trap_perm);
    end
    @(negedge clk);
    checks++;
    if (trap_perm !== 1'b1 || redirect !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL %s_in_trap got tp=%b rd=%b fl=%b expected tp=1 rd=0 fl=0",
               name, trap_perm, redirect, flush);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_csr_pending got %0d writes outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_load_misalign();
    pc_f = 64'h80100;
    repeat (3) @(negedge clk);
    code_e  = E_LOAD_ADDR_MISALIGNED;
    alu_out = 64'h100002;
    push(12'h341, 64'h80100);
    push(12'h342, 64'd4);
    push(12'h343, 64'h100002);
    @(negedge clk);
    code_e = NO_E;
    checks++;
    if (flush !== 1'b1 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL load_t_epc got fl=%b rd=%b expected fl=1 rd=0", flush, redirect);
    end
    finish_entry("load");
  endtask

  task automatic test_mret(input logic [W-1:0] ret_pc);
    mepc = ret_pc;
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    checks++;
    if (flush !== 1'b1 || redirect !== 1'b1 || target !== ret_pc || trap_perm !== 1'b1 || csr_we !== 1'b0) begin
      errors++;
      $display("FAIL mret_ret got fl=%b rd=%b tgt=%h tp=%b we=%b expected fl=1 rd=1 tgt=%h tp=1 we=0",
               flush, redirect, target, trap_perm, csr_we, ret_pc);
    end
    @(negedge clk);
    checks++;
    if (trap_perm !== 1'b0 || redirect !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL mret_idle got tp=%b rd=%b fl=%b expected 0 0 0", trap_perm, redirect, flush);
    end
  endtask

  task automatic test_fetch_misalign();
    code_f = E_INSTR_ADDR_MISALIGNED;
    pc_f   = 64'h80002;
    @(negedge clk);
    code_f = NO_E;
    pc_f   = 64'h80006;
    stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (flush !== 1'b0) begin
        errors++;
        $display("FAIL fetch_stall_hold cycle %0d got flush=%b expected 0", i, flush);
      end
    end
    stall = 1'b0;
    push(12'h341, 64'h80002);
    push(12'h342, 64'd0);
    push(12'h343, 64'h80002);
    @(negedge clk);
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL fetch_early got flush=%b expected 0", flush);
    end
    @(negedge clk);
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL fetch_raise got flush=%b expected 1", flush);
    end
    finish_entry("fetch");
    test_mret(64'h80010);
  endtask

  task automatic test_priority();
    code_f = E_INSTR_ACCESS_FAULT;
    pc_f   = 64'h80020;
    @(negedge clk);
    code_f = NO_E;
    pc_f   = 64'h80024;
    @(negedge clk);
    code_e  = E_ECALL;
    alu_out = 64'hdead;
    push(12'h341, 64'h80020);
    push(12'h342, 64'd11);
    push(12'h343, 64'd0);
    @(negedge clk);
    code_e = NO_E;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL prio_t_epc got flush=%b expected 1", flush);
    end
    finish_entry("prio");
  endtask

  task automatic test_double_fault();
    code_e = E_ILLEGAL_INSTR;
    mret   = 1'b1;
    @(negedge clk);
    code_e = NO_E;
    mret   = 1'b0;
    checks++;
    if (halt !== 1'b1 || flush !== 1'b1 || csr_we !== 1'b0 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL dfault_halt got h=%b fl=%b we=%b rd=%b expected 1 1 0 0", halt, flush, csr_we, redirect);
    end
    mret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (halt !== 1'b1 || redirect !== 1'b0) begin
        errors++;
        $display("FAIL dfault_sticky cycle %0d got h=%b rd=%b expected h=1 rd=0", i, halt, redirect);
      end
    end
    mret = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (halt !== 1'b0 || flush !== 1'b0 || trap_perm !== 1'b0) begin
      errors++;
      $display("FAIL dfault_reset got h=%b fl=%b tp=%b expected 0 0 0", halt, flush, trap_perm);
    end
  endtask

  task automatic test_reset_mid();
    pc_f = 64'h80024;
    repeat (3) @(negedge clk);
    code_e  = E_STORE_ADDR_MISALIGNED;
    alu_out = 64'h100040;
    push(12'h341, 64'h80024);
    @(negedge clk);
    code_e = NO_E;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (csr_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop got we=%b expected 0", csr_we);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (flush !== 1'b0 || trap_perm !== 1'b0 || redirect !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_idle cycle %0d got fl=%b tp=%b rd=%b expected 0 0 0", i, flush, trap_perm, redirect);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_pending got %0d writes outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_misalign();
    test_mret(64'h80010);
    test_fetch_misalign();
    test_priority();
    test_double_fault();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Consumes the per-stage exception codes from the exception signal handler and turns them into a precise trap entry or MRET return.
- Carries fetch-stage exception codes alongside the F->D->E pipeline, so each fetch fault is raised only when its instruction reaches Execute.
- Serialises the mepc/mcause/mtval CSR writes over a one-port interface.
- Flushes and redirects the pipeline and owns the trap/reset permission bits fed back to the exception handler.

Parameters:
XLEN, `XLEN_64b, width selector; datapath width W = 1<<(XLEN+4).
TRAP_VECTOR, 0, PC loaded on trap entry (region pc[20:18]=000).

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous, active-high reset.
i_exception_code_f  in  4  fetch-stage code, `NO_E when none.
i_exception_code_e  in  4  execute-stage code.
i_pc_f  in  W  PC of the fetched instruction.
i_alu_out_e  in  W  Execute address/result; used as mtval for load/store faults.
i_mret_e  in  1  MRET in Execute.
i_stall  in  1  pipeline stall; F/D carry registers hold.
i_mepc  in  W  current mepc CSR value, read on MRET.
o_csr_we  out  1  CSR write strobe.
o_csr_addr  out  12  0x341 mepc, 0x342 mcause, 0x343 mtval.
o_csr_wdata  out  W  CSR write data.
o_flush  out  1  flush F, D and E stage registers.
o_pc_redirect  out  1  load o_pc_target into PC this cycle.
o_pc_target  out  W  redirect target.
o_trap_permission  out  1  to exception handler.
o_reset_permission  out  1  to exception handler.
o_halt  out  1  double fault; core stopped.

Behaviour:
- Reset values: all outputs 0 except o_reset_permission=1; state IDLE; carry registers hold `NO_E with PC 0.
- o_reset_permission clears on the first cycle in IDLE with i_pc_f[20:18]=3'b010 and i_exception_code_f=`NO_E. It never sets again until reset.
- F-code carry: two stages, {code, pc} F->D and D->E.
  - Advances only when !i_stall.
  - o_flush loads `NO_E into both stages.
- Effective E code: i_exception_code_e if not `NO_E, else the carried D->E code. Execute wins on a simultaneous event (same instruction, older cause).
- Captured on a trap: cause, epc (carried PC if the fetch code was chosen, else PC of the E instruction, held in the carry), tval.
  - tval = i_alu_out_e for load/store codes.
  - tval = carried PC for a fetch misalign.
  - tval = 0 otherwise.
- State IDLE (o_trap_permission=0): effective code != `NO_E at an edge -> T_EPC.
- i_mret_e in IDLE is illegal: it is captured as `E_ILLEGAL_INSTR and takes the same trap path.
- State T_EPC: o_flush=1, o_csr_we=1, addr 0x341, data=epc -> T_CAUSE.
- State T_CAUSE: o_flush=1, CSR write 0x342, data = zero-extended cause -> T_TVAL.
- State T_TVAL: o_flush=1, CSR write 0x343; o_pc_redirect=1, o_pc_target=TRAP_VECTOR -> IN_TRAP.
- Trap latency: exception sampled at edge N; redirect asserted in cycle N+3; o_trap_permission=1 from cycle N+4.
- State IN_TRAP (o_trap_permission=1):
  - i_mret_e -> RET.
  - Any effective exception code -> HALT (double fault); exception wins over MRET in the same cycle.
- State RET: o_flush=1, o_pc_redirect=1, o_pc_target=i_mepc, o_trap_permission stays 1 -> IDLE with permission 0 next cycle.
- State HALT: o_halt=1 and o_flush=1 held; no CSR writes; exits only on i_rst.
- Inputs are ignored in T_EPC, T_CAUSE, T_TVAL and RET; the flush guarantees no new faults.
- i_stall does not delay the FSM.
- Reset mid-sequence: abort to IDLE the same edge; any CSR write not yet issued is dropped.
- o_csr_we is asserted only in the three T_* states, exactly once per state.

Decomposition:
- Shared constants header (existing Constants.vh): add CSR addresses MEPC/MCAUSE/MTVAL, the state encodings, and TRAP_VECTOR default. Reuse the existing `E_* and `NO_E.
- One sub-module, trap_code_pipe: the two-stage F->D->E code/PC carry with stall and flush.

Test Plan:
- Load misalign: E code `E_LOAD_ADDR_MISALIGNED with alu_out 0x100002 at edge N -> CSR writes in order 0x341=PC_e, 0x342=code, 0x343=0x100002; redirect to 0 at N+3; trap_permission=1 at N+4.
- Fetch misalign: F code with pc_f 0x80002, no stall -> trap raised two advances later; mepc=mtval=0x80002; while i_stall=1 the carry holds and no trap is raised.
- Priority: carried fetch code and E `E_ECALL in the same cycle -> mcause=`E_ECALL.
- MRET: IN_TRAP with i_mepc=0x80010, mret_e=1 -> one cycle of flush plus redirect to 0x80010; next cycle IDLE, trap_permission=0.
- Double fault: `E_ILLEGAL_INSTR while IN_TRAP -> o_halt=1, no CSR write; remains halted until i_rst.
- Reset behaviour: i_rst during T_CAUSE -> IDLE, no 0x342/0x343 write. Separately, after reset the first clean pc_f=0x80000 clears o_reset_permission.
